vxe_vpu_stor_eu: RTL and testbench
==================================

# vxe_vpu_stor_eu

Store execution unit of the VxE vector processing unit. It is the responder to the store ECU's `o_eu_start`/`i_eu_busy` handshake. On start it reads 32-bit elements from the thread register file, packs them into 64-bit memory words with byte enables, and issues write requests to the memory port. It holds busy until the store completes.

## Interface
- `OUTST_MAX`, default 8: maximum outstanding write requests not yet acknowledged (power of two, 2..16).
- `clk` input 1: clock.
- `nrst` input 1: asynchronous, active-low reset.
- `i_start` input 1: start pulse from store ECU; sampled only in IDLE.
- `o_busy` output 1: unit busy; consumed by ECU as `i_eu_busy`.
- `i_addr` input 38: destination address in 32-bit element units; bit 0 selects the half of the 64-bit word.
- `i_len` input 20: element count; 0 is legal.
- `o_rf_rd` output 1: register file read strobe.
- `o_rf_idx` output 20: element index to read.
- `i_rf_data` input 32: read data.
- `i_rf_vld` input 1: read data valid; arrives exactly 1 cycle after `o_rf_rd`.
- `o_mem_req` output 1: write request valid.
- `o_mem_addr` output 37: 64-bit word address.
- `o_mem_data` output 64: write data; element at even address in [31:0].
- `o_mem_ben` output 8: byte enables.
- `i_mem_rdy` input 1: request accepted when `o_mem_req && i_mem_rdy`.
- `i_mem_ack` input 1: one write response per accepted request.

## Operation
- **States:** IDLE, FETCH, WAITD, SEND, DRAIN.
- **IDLE:**
  - On `i_start`: latch `i_addr` and `i_len`, clear the element counter and the pack register, and set `o_busy`.
  - If `len==0`, go to DRAIN; otherwise go to FETCH.
- **FETCH:**
  - If outstanding count < `OUTST_MAX`, pulse `o_rf_rd` with `o_rf_idx` = element counter, then go to WAITD.
  - Otherwise stay in FETCH.
- **WAITD:**
  - On `i_rf_vld`, place the data in the half given by the current address bit 0 and set the matching nibble of the ben (0x0F low, 0xF0 high).
  - Increment the element counter and the address.
  - Go to SEND if the word is complete (high half written) or this was the last element; otherwise go to FETCH.
- **SEND:**
  - Hold `o_mem_req` with stable addr, data and ben until `i_mem_rdy`.
  - On acceptance, clear the pack register.
  - Go to FETCH if elements remain; otherwise go to DRAIN.
- **DRAIN:** wait until the outstanding count is 0, then clear `o_busy` and go to IDLE.
- **Outstanding counter:**
  - Width is clog2(`OUTST_MAX`)+1.
  - Increments on request acceptance and decrements on `i_mem_ack`.
  - Simultaneous accept and ack leaves it unchanged.
  - An ack arriving when the count is 0 is ignored and the count stays 0.
- **Odd start address:** the first word has ben 0xF0.
- **Odd end:** the last word has ben 0x0F.
- **Address wrap:** wraps modulo 2^38 with no error.
- **Start while busy:** `i_start` is ignored in every state except IDLE.

## Timing
- **Reset values:** all outputs 0, state IDLE, counters 0.
- **Busy assertion:** `o_busy` rises the cycle after `i_start` is sampled. The ECU samples busy two cycles after start, so this requirement is met.
- **Zero length:** `len==0` gives `o_busy` high for exactly 1 cycle.
- **Throughput:** one element per 2 cycles (FETCH+WAITD), plus ≥1 SEND cycle per word.
- **End latency:** `o_busy` falls 1 cycle after the final ack is seen in DRAIN.
- **Registered outputs:** all outputs are registered.
- **Reset mid-operation:** returns immediately to IDLE. Pending acks after reset are ignored because the counter is 0.

## Configuration
- **Macro:** `VXE_VPU_STOR_EU_WRRESP_EN`.
- **Defined:** DRAIN waits for all write acks as described above, and FETCH throttles on `OUTST_MAX`.
- **Undefined:**
  - `i_mem_ack` is unused and the outstanding counter is removed.
  - FETCH never throttles.
  - DRAIN exits immediately, so `o_busy` falls the cycle after the last request is accepted.

## Structure
- **Shared package `vxe_vpu_pkg`:**
  - State encodings.
  - Ben constants `BEN_LO`=8'h0F, `BEN_HI`=8'hF0.
  - Element and word address width constants, shared with the load EU.
- **Sub-module `vxe_vpu_stor_pack`:**
  - Holds the 64-bit data and ben register.
  - Supports lane insert and clear.
  - Provides a word-complete flag.
- The FSM and counters stay in the top module.

## Test plan
- **Aligned, immediate acks:** addr=0x10, len=4, `i_mem_rdy`=1, ack 1 cycle after accept -> 2 requests:
  - addr 0x8, ben 0xFF, data {e1,e0};
  - addr 0x9, ben 0xFF, data {e3,e2};
  - busy falls after the 2nd ack.
- **Unaligned, odd length:** addr=0x11, len=4 -> 3 requests:
  - 0x8 with ben 0xF0 data[63:32]=e0;
  - 0x9 with ben 0xFF;
  - 0xA with ben 0x0F data[31:0]=e3.
- **Zero length:** len=0 -> `o_busy` high for one cycle, no `o_rf_rd`, no `o_mem_req`.
- **Backpressure and throttling:**
  - Setup: `i_mem_rdy` low for 5 cycles on the first request, `OUTST_MAX`=2, acks withheld.
  - Required: request signals stable while `i_mem_rdy` is low.
  - Required: FETCH stalls after 2 accepts and resumes on the first ack.
- **Start ignored while busy:** a 2nd `i_start` pulse while busy -> ignored, and the latched len/addr are unchanged.
- **Reset mid-store:** `nrst` low during SEND -> all outputs 0 next cycle; a late ack after reset leaves the count at 0.

Source files
------------

// File: rtl/vxe_vpu_pkg.sv
// Shared VxE VPU definitions: execution-unit state encodings, byte-enable
// lane constants and element/word address widths used by the load and store EUs.
package vxe_vpu_pkg;

  localparam int ELEM_W  = 32;
  localparam int WORD_W  = 64;
  localparam int BEN_W   = 8;
  localparam int ELEM_AW = 38;
  localparam int WORD_AW = 37;
  localparam int LEN_W   = 20;

  localparam logic [BEN_W-1:0] BEN_LO = 8'h0F;
  localparam logic [BEN_W-1:0] BEN_HI = 8'hF0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAITD = 3'd2,
    ST_SEND  = 3'd3,
    ST_DRAIN = 3'd4
  } stor_st_e;

endpackage

// File: rtl/vxe_vpu_stor_pack.sv
// Store EU pack register: assembles two 32-bit elements into one 64-bit
// memory word with byte enables; exposes a word-complete flag.
module vxe_vpu_stor_pack
  import vxe_vpu_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              clr,
  input  logic              ins,
  input  logic              hi,
  input  logic [ELEM_W-1:0] din,
  output logic [WORD_W-1:0] data,
  output logic [BEN_W-1:0]  ben,
  output logic              cmpl
);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data <= '0;
      ben  <= '0;
    end else if (clr) begin
      data <= '0;
      ben  <= '0;
    end else if (ins) begin
      if (hi) begin
        data[WORD_W-1:ELEM_W] <= din;
        ben                   <= ben | BEN_HI;
      end else begin
        data[ELEM_W-1:0] <= din;
        ben              <= ben | BEN_LO;
      end
    end
  end

  // The word is complete once its high lane is written, including this cycle's insert.
  assign cmpl = ben[BEN_W-1] | (ins & hi);

endmodule

// File: rtl/vxe_vpu_stor_eu.sv
// VxE VPU store execution unit: reads elements from the thread RF, packs them
// into 64-bit words and issues memory writes. Option: VXE_VPU_STOR_EU_WRRESP_EN.
module vxe_vpu_stor_eu
  import vxe_vpu_pkg::*;
#(
  parameter int OUTST_MAX = 8
)
(
  input  logic               clk,
  input  logic               nrst,
  input  logic               i_start,
  output logic               o_busy,
  input  logic [ELEM_AW-1:0] i_addr,
  input  logic [LEN_W-1:0]   i_len,
  output logic               o_rf_rd,
  output logic [LEN_W-1:0]   o_rf_idx,
  input  logic [ELEM_W-1:0]  i_rf_data,
  input  logic               i_rf_vld,
  output logic               o_mem_req,
  output logic [WORD_AW-1:0] o_mem_addr,
  output logic [WORD_W-1:0]  o_mem_data,
  output logic [BEN_W-1:0]   o_mem_ben,
  input  logic               i_mem_rdy,
  input  logic               i_mem_ack
);

  stor_st_e           st_q, st_nxt;
  logic [ELEM_AW-1:0] addr_q, addr_nxt;
  logic [LEN_W-1:0]   len_q, len_nxt;
  logic [LEN_W-1:0]   cnt_q, cnt_nxt, cnt_inc;
  logic               busy_nxt, rd_nxt, req_nxt;
  logic [LEN_W-1:0]   idx_nxt;
  logic [WORD_AW-1:0] maddr_nxt;
  logic               pk_clr, pk_ins, pk_cmpl;
  logic               accept, can_fetch, drain_done;

  assign accept  = o_mem_req & i_mem_rdy;
  assign cnt_inc = cnt_q + 1'b1;

`ifdef VXE_VPU_STOR_EU_WRRESP_EN
  localparam int OW = $clog2(OUTST_MAX) + 1;
  localparam logic [OW-1:0] OMAX = OW'(OUTST_MAX);

  logic [OW-1:0] outst_q, outst_nxt;
  logic          ack_eff;

  // An ack with nothing outstanding (e.g. a straggler after reset) is dropped.
  assign ack_eff = i_mem_ack & (outst_q != '0);

  always_comb begin
    outst_nxt = outst_q;
    unique case ({accept, ack_eff})
      2'b10:   outst_nxt = outst_q + 1'b1;
      2'b01:   outst_nxt = outst_q - 1'b1;
      default: outst_nxt = outst_q;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) outst_q <= '0;
    else       outst_q <= outst_nxt;
  end

  assign can_fetch  = (outst_q < OMAX);
  assign drain_done = (outst_nxt == '0);
`else
  logic unused_ack;
  assign unused_ack = i_mem_ack;
  assign can_fetch  = 1'b1;
  assign drain_done = 1'b1;
`endif

  vxe_vpu_stor_pack u_pack (
    .clk  (clk),
    .nrst (nrst),
    .clr  (pk_clr),
    .ins  (pk_ins),
    .hi   (addr_q[0]),
    .din  (i_rf_data),
    .data (o_mem_data),
    .ben  (o_mem_ben),
    .cmpl (pk_cmpl)
  );

  always_comb begin
    st_nxt    = st_q;
    addr_nxt  = addr_q;
    len_nxt   = len_q;
    cnt_nxt   = cnt_q;
    busy_nxt  = o_busy;
    rd_nxt    = 1'b0;
    idx_nxt   = o_rf_idx;
    req_nxt   = o_mem_req;
    maddr_nxt = o_mem_addr;
    pk_clr    = 1'b0;
    pk_ins    = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_nxt = i_addr;
          len_nxt  = i_len;
          cnt_nxt  = '0;
          pk_clr   = 1'b1;
          busy_nxt = 1'b1;
          st_nxt   = (i_len == '0) ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (can_fetch) begin
          rd_nxt  = 1'b1;
          idx_nxt = cnt_q;
          st_nxt  = ST_WAITD;
        end
      end
      ST_WAITD: begin
        if (i_rf_vld) begin
          pk_ins   = 1'b1;
          cnt_nxt  = cnt_inc;
          addr_nxt = addr_q + 1'b1;
          if (pk_cmpl || (cnt_inc == len_q)) begin
            req_nxt   = 1'b1;
            maddr_nxt = addr_q[ELEM_AW-1:1];
            st_nxt    = ST_SEND;
          end else begin
            st_nxt = ST_FETCH;
          end
        end
      end
      ST_SEND: begin
        if (accept) begin
          req_nxt = 1'b0;
          pk_clr  = 1'b1;
          st_nxt  = (cnt_q == len_q) ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (drain_done) begin
          busy_nxt = 1'b0;
          st_nxt   = ST_IDLE;
        end
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st_q       <= ST_IDLE;
      cnt_q      <= '0;
      o_busy     <= 1'b0;
      o_rf_rd    <= 1'b0;
      o_rf_idx   <= '0;
      o_mem_req  <= 1'b0;
      o_mem_addr <= '0;
    end else begin
      st_q       <= st_nxt;
      cnt_q      <= cnt_nxt;
      o_busy     <= busy_nxt;
      o_rf_rd    <= rd_nxt;
      o_rf_idx   <= idx_nxt;
      o_mem_req  <= req_nxt;
      o_mem_addr <= maddr_nxt;
    end
  end

  // Latched command operands are only meaningful while busy.
  always_ff @(posedge clk) begin
    addr_q <= addr_nxt;
    len_q  <= len_nxt;
  end

endmodule

// File: tb/tb_vxe_vpu_stor_eu.sv
// Directed scoreboard bench for vxe_vpu_stor_eu (builds with or without
// VXE_VPU_STOR_EU_WRRESP_EN); OUTST_MAX is 2 so throttling is reachable.
module tb_vxe_vpu_stor_eu;
  import vxe_vpu_pkg::*;

  localparam int OUTST = 2;

  logic               clk = 1'b0;
  logic               nrst;
  logic               i_start;
  logic               o_busy;
  logic [ELEM_AW-1:0] i_addr;
  logic [LEN_W-1:0]   i_len;
  logic               o_rf_rd;
  logic [LEN_W-1:0]   o_rf_idx;
  logic [ELEM_W-1:0]  i_rf_data;
  logic               i_rf_vld;
  logic               o_mem_req;
  logic [WORD_AW-1:0] o_mem_addr;
  logic [WORD_W-1:0]  o_mem_data;
  logic [BEN_W-1:0]   o_mem_ben;
  logic               i_mem_rdy;
  logic               i_mem_ack;

  vxe_vpu_stor_eu #(.OUTST_MAX(OUTST)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .i_start    (i_start),
    .o_busy     (o_busy),
    .i_addr     (i_addr),
    .i_len      (i_len),
    .o_rf_rd    (o_rf_rd),
    .o_rf_idx   (o_rf_idx),
    .i_rf_data  (i_rf_data),
    .i_rf_vld   (i_rf_vld),
    .o_mem_req  (o_mem_req),
    .o_mem_addr (o_mem_addr),
    .o_mem_data (o_mem_data),
    .o_mem_ben  (o_mem_ben),
    .i_mem_rdy  (i_mem_rdy),
    .i_mem_ack  (i_mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WORD_AW-1:0] a;
    logic [WORD_W-1:0]  d;
    logic [BEN_W-1:0]   b;
  } req_t;

  req_t        exp_q[$];
  int          nvec = 0;
  int          nmis = 0;
  int          pend = 0;
  int          acc_cnt = 0;
  int          ack_cnt = 0;
  int          rd_cnt = 0;
  int          busy_cnt = 0;
  int          req_cyc = 0;
  logic        ack_en;
  logic        ack_force;
  logic [31:0] seed;

  function automatic logic [31:0] elem(input logic [LEN_W-1:0] idx);
    return seed ^ ({12'h0, idx} * 32'h0100_0193);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    assert (obs === expv)
    else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference packing: walk elements, start a new word whenever the word address changes.
  task automatic push_exp(input logic [ELEM_AW-1:0] addr, input logic [LEN_W-1:0] len);
    req_t               cur;
    logic [ELEM_AW-1:0] a;
    logic               have;
    have = 1'b0;
    cur  = '0;
    for (int i = 0; i < int'(len); i++) begin
      a = addr + ELEM_AW'(i);
      if (have && (cur.a != a[ELEM_AW-1:1])) begin
        exp_q.push_back(cur);
        cur = '0;
      end
      have  = 1'b1;
      cur.a = a[ELEM_AW-1:1];
      if (a[0]) begin
        cur.d[63:32] = elem(LEN_W'(i));
        cur.b[7:4]   = 4'hF;
      end else begin
        cur.d[31:0]  = elem(LEN_W'(i));
        cur.b[3:0]   = 4'hF;
      end
    end
    if (have) exp_q.push_back(cur);
  endtask

  // Called at a negedge with inputs already set for the coming posedge.
  task automatic tick();
    req_t got, want;
    if (!nrst) pend = 0;
    i_rf_vld  = o_rf_rd;
    i_rf_data = elem(o_rf_idx);
    i_mem_ack = ack_force;
    if (nrst && ack_en && pend > 0) begin
      i_mem_ack = 1'b1;
      pend--;
      ack_cnt++;
    end
    if (o_rf_rd) rd_cnt++;
    if (o_busy) busy_cnt++;
    if (o_mem_req) req_cyc++;
    if (nrst && o_mem_req && i_mem_rdy) begin
      acc_cnt++;
      pend++;
      got = {o_mem_addr, o_mem_data, o_mem_ben};
      chk("req_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        chk("mem_addr", 64'(got.a), 64'(want.a));
        chk("mem_data", got.d, want.d);
        chk("mem_ben", 64'(got.b), 64'(want.b));
      end
    end
    @(negedge clk);
  endtask

  task automatic run_store(input logic [ELEM_AW-1:0] addr, input logic [LEN_W-1:0] len,
                           input logic [31:0] sd);
    seed = sd;
    push_exp(addr, len);
    i_addr  = addr;
    i_len   = len;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_addr  = '0;
    i_len   = '0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n;
    n = 0;
    while (o_busy && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, 64'(o_busy), 64'd0);
  endtask

  task automatic wait_req(input string tag, input int maxc);
    int n;
    n = 0;
    while (!o_mem_req && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, 64'(o_mem_req), 64'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
    chk({tag, "_rf_rd"}, 64'(o_rf_rd), 64'd0);
    chk({tag, "_rf_idx"}, 64'(o_rf_idx), 64'd0);
    chk({tag, "_mem_req"}, 64'(o_mem_req), 64'd0);
    chk({tag, "_mem_addr"}, 64'(o_mem_addr), 64'd0);
    chk({tag, "_mem_data"}, o_mem_data, 64'd0);
    chk({tag, "_mem_ben"}, 64'(o_mem_ben), 64'd0);
  endtask

  initial begin
    int a0, k0, r0, b0, q0;
    logic [WORD_AW-1:0] sa;
    logic [WORD_W-1:0]  sd;
    logic [BEN_W-1:0]   sb;

    nrst = 1'b0; i_start = 1'b0; i_addr = '0; i_len = '0;
    i_rf_vld = 1'b0; i_rf_data = '0; i_mem_rdy = 1'b0; i_mem_ack = 1'b0;
    ack_en = 1'b1; ack_force = 1'b0; seed = '0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("rst");
    nrst = 1'b1;
    tick();

    // Aligned store with immediate acks
    i_mem_rdy = 1'b1;
    chk("busy_pre", 64'(o_busy), 64'd0);
    a0 = acc_cnt; k0 = ack_cnt;
    run_store(38'h10, 20'd4, 32'hA5A5_0001);
    chk("busy_rise", 64'(o_busy), 64'd1);
    wait_idle("aligned_idle", 100);
    chk("aligned_accepts", 64'(acc_cnt - a0), 64'd2);
    chk("aligned_acks_before_idle", 64'(ack_cnt - k0), 64'd2);
    chk("aligned_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();

    // Unaligned start, odd end
    a0 = acc_cnt;
    run_store(38'h11, 20'd4, 32'h3C3C_1234);
    wait_idle("unaligned_idle", 100);
    chk("unaligned_accepts", 64'(acc_cnt - a0), 64'd3);
    chk("unaligned_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();

    // Zero length
    b0 = busy_cnt; r0 = rd_cnt; q0 = req_cyc;
    run_store(38'h30, 20'd0, 32'h0);
    repeat (6) tick();
    chk("zero_busy_cycles", 64'(busy_cnt - b0), 64'd1);
    chk("zero_rf_reads", 64'(rd_cnt - r0), 64'd0);
    chk("zero_mem_reqs", 64'(req_cyc - q0), 64'd0);

    // Address wrap at the top of the element space
    a0 = acc_cnt;
    run_store(38'h3F_FFFF_FFFF, 20'd3, 32'h5555_AAAA);
    wait_idle("wrap_idle", 100);
    chk("wrap_accepts", 64'(acc_cnt - a0), 64'd2);
    chk("wrap_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();

    // Backpressure then outstanding-limit throttling
    ack_en = 1'b0; i_mem_rdy = 1'b0;
    a0 = acc_cnt; r0 = rd_cnt;
    run_store(38'h0, 20'd8, 32'hDEAD_0000);
    wait_req("bp_first_req", 30);
    sa = o_mem_addr; sd = o_mem_data; sb = o_mem_ben;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_req_held", 64'(o_mem_req), 64'd1);
      chk("bp_addr_stable", 64'(o_mem_addr), 64'(sa));
      chk("bp_data_stable", o_mem_data, sd);
      chk("bp_ben_stable", 64'(o_mem_ben), 64'(sb));
    end
    i_mem_rdy = 1'b1;
    repeat (30) tick();
`ifdef VXE_VPU_STOR_EU_WRRESP_EN
    chk("throttle_accepts", 64'(acc_cnt - a0), 64'd2);
    chk("throttle_reads", 64'(rd_cnt - r0), 64'd4);
    chk("throttle_busy", 64'(o_busy), 64'd1);
`else
    chk("nothrottle_accepts", 64'(acc_cnt - a0), 64'd4);
    chk("nothrottle_reads", 64'(rd_cnt - r0), 64'd8);
`endif
    ack_en = 1'b1;
    wait_idle("throttle_idle", 100);
    chk("throttle_total_accepts", 64'(acc_cnt - a0), 64'd4);
    chk("throttle_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (6) tick();

    // Second start while busy must be ignored
    a0 = acc_cnt;
    run_store(38'h10, 20'd4, 32'h0F0F_7777);
    tick();
    i_addr = 38'h40; i_len = 20'd2; i_start = 1'b1;
    tick();
    i_start = 1'b0; i_addr = '0; i_len = '0;
    wait_idle("ignore_idle", 100);
    chk("ignore_accepts", 64'(acc_cnt - a0), 64'd2);
    chk("ignore_q_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();

    // Reset during SEND, then a stray ack
    i_mem_rdy = 1'b0;
    run_store(38'h10, 20'd4, 32'h1357_9BDF);
    wait_req("rst_reach_send", 30);
    nrst = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    tick();
    tick();
    exp_q.delete();
    nrst = 1'b1;
    tick();
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    tick();
    i_mem_rdy = 1'b1;
    a0 = acc_cnt;
    run_store(38'h20, 20'd2, 32'h2468_ACE0);
    wait_idle("postrst_idle", 100);
    chk("postrst_accepts", 64'(acc_cnt - a0), 64'd1);
    chk("postrst_q_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
